// File: rtl/truth_table_scanner.sv
// Stimulus/capture engine: sweeps {x,y,z} through all 8 vectors, samples f7/f8/f9
// into truth tables and compares them against latched expected masks.
module truth_table_scanner #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] exp7,
  input  logic [7:0] exp8,
  input  logic [7:0] exp9,
  input  logic       f7,
  input  logic       f8,
  input  logic       f9,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err,
  output logic [7:0] tt7,
  output logic [7:0] tt8,
  output logic [7:0] tt9
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_r, state_s;
  logic [2:0] idx_r;
  logic [2:0] xyz_r;
  logic [3:0] cnt_r;
  logic [7:0] exp7_r, exp8_r, exp9_r;
  logic [7:0] tt7_r, tt8_r, tt9_r;
  logic [7:0] tt7_s, tt8_s, tt9_s;
  logic [2:0] err_r, err_s;
  logic       busy_r, done_r, pass_r;
  logic       settle_end_s, last_s;

  assign settle_end_s = (cnt_r == CNT_LAST);
  assign last_s       = (idx_r == 3'd7);

  // Tables as they will be after the current sample, so the final compare sees the last bit
  always_comb begin
    tt7_s        = tt7_r;
    tt8_s        = tt8_r;
    tt9_s        = tt9_r;
    tt7_s[idx_r] = f7;
    tt8_s[idx_r] = f8;
    tt9_s[idx_r] = f9;
    err_s        = {(tt7_s != exp7_r), (tt8_s != exp8_r), (tt9_s != exp9_r)};
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_s = ST_SETTLE;
        else       state_s = state_r;
      end
      ST_SETTLE: begin
        if (settle_end_s) state_s = ST_SAMPLE;
        else              state_s = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (last_s) state_s = ST_DONE;
        else        state_s = ST_SETTLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Stimulus, capture and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r  <= 3'd0;
      xyz_r  <= 3'd0;
      cnt_r  <= 4'd0;
      exp7_r <= 8'd0;
      exp8_r <= 8'd0;
      exp9_r <= 8'd0;
      tt7_r  <= 8'd0;
      tt8_r  <= 8'd0;
      tt9_r  <= 8'd0;
      err_r  <= 3'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            exp7_r <= exp7;
            exp8_r <= exp8;
            exp9_r <= exp9;
            tt7_r  <= 8'd0;
            tt8_r  <= 8'd0;
            tt9_r  <= 8'd0;
            err_r  <= 3'd0;
            pass_r <= 1'b0;
            done_r <= 1'b0;
            idx_r  <= 3'd0;
            xyz_r  <= 3'd0;
            cnt_r  <= 4'd0;
            busy_r <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt_r <= cnt_r + 4'd1;
        end
        ST_SAMPLE: begin
          tt7_r <= tt7_s;
          tt8_r <= tt8_s;
          tt9_r <= tt9_s;
          if (last_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            err_r  <= err_s;
            pass_r <= ~|err_s;
          end else begin
            idx_r <= idx_r + 3'd1;
            xyz_r <= idx_r + 3'd1;
            cnt_r <= 4'd0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign x    = xyz_r[2];
  assign y    = xyz_r[1];
  assign z    = xyz_r[0];
  assign busy = busy_r;
  assign done = done_r;
  assign pass = pass_r;
  assign err  = err_r;
  assign tt7  = tt7_r;
  assign tt8  = tt8_r;
  assign tt9  = tt9_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: directed scans plus randomized block tables,
// checked against a cycle-count/table model of the scan.
module tb_truth_table_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic [7:0] exp7, exp8, exp9;
  logic [7:0] blk7, blk8, blk9;

  logic       x0, y0, z0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [7:0] tt7_0, tt8_0, tt9_0;
  logic       f7_0, f8_0, f9_0;

  logic       x1, y1, z1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [7:0] tt7_1, tt8_1, tt9_1;
  logic       f7_1, f8_1, f9_1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Block under test: a lookup of the current table on each scanner's stimulus
  assign f7_0 = blk7[{x0, y0, z0}];
  assign f8_0 = blk8[{x0, y0, z0}];
  assign f9_0 = blk9[{x0, y0, z0}];
  assign f7_1 = blk7[{x1, y1, z1}];
  assign f8_1 = blk8[{x1, y1, z1}];
  assign f9_1 = blk9[{x1, y1, z1}];

  truth_table_scanner #(.SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .exp7(exp7), .exp8(exp8), .exp9(exp9),
    .f7(f7_0), .f8(f8_0), .f9(f9_0),
    .x(x0), .y(y0), .z(z0), .busy(busy0), .done(done0), .pass(pass0), .err(err0),
    .tt7(tt7_0), .tt8(tt8_0), .tt9(tt9_0)
  );

  truth_table_scanner #(.SETTLE_CYC(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .exp7(exp7), .exp8(exp8), .exp9(exp9),
    .f7(f7_1), .f8(f8_1), .f9(f9_1),
    .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1), .pass(pass1), .err(err1),
    .tt7(tt7_1), .tt8(tt8_1), .tt9(tt9_1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  function automatic logic [4:0] status(input int sel);
    if (sel != 0) return {busy1, done1, x1, y1, z1};
    else          return {busy0, done0, x0, y0, z0};
  endfunction

  function automatic logic [27:0] result(input int sel);
    if (sel != 0) return {pass1, err1, tt7_1, tt8_1, tt9_1};
    else          return {pass0, err0, tt7_0, tt8_0, tt9_0};
  endfunction

  // One full scan: vector k is expected for cycles k*(s+1) .. k*(s+1)+s after the start edge
  task automatic do_scan(input int sel, input int s, input int inj_at, input int chg_at,
                         input int abort_at);
    logic [7:0] e7, e8, e9;
    logic [2:0] e_err;
    int         len;
    e7  = exp7;
    e8  = exp8;
    e9  = exp9;
    len = 8 * (s + 1);
    if (sel != 0) start1 = 1'b1;
    else          start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_status", 32'(status(sel)), 32'd0);
        check("abort_result", 32'(result(sel)), 32'd0);
        rst_n = 1'b1;
        return;
      end
      check("run_status", 32'(status(sel)), 32'({2'b10, 3'(c / (s + 1))}));
      if (c == inj_at) begin
        if (sel != 0) start1 = 1'b1;
        else          start0 = 1'b1;
      end
      if (c == chg_at) exp7 = 8'h00;
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
    end
    e_err = {(blk7 != e7), (blk8 != e8), (blk9 != e9)};
    check("end_status", 32'(status(sel)), 32'(5'b01111));
    check("end_result", 32'(result(sel)), 32'({(e_err == 3'b000), e_err, blk7, blk8, blk9}));
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b1;
    start1 = 1'b1;
    blk7   = 8'hFF;
    blk8   = 8'hFF;
    blk9   = 8'hFF;
    exp7   = 8'hBE;
    exp8   = 8'hBE;
    exp9   = 8'hBE;
    repeat (3) @(negedge clk);
    check("rst_status0", 32'(status(0)), 32'd0);
    check("rst_result0", 32'(result(0)), 32'd0);
    check("rst_status1", 32'(status(1)), 32'd0);
    check("rst_result1", 32'(result(1)), 32'd0);
    rst_n  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    check("idle_status", 32'(status(0)), 32'd0);

    // f = (x+y+z)(x'+y'+z) is 0 only at vectors 0 and 6
    blk7 = 8'hBE;
    blk8 = 8'hBE;
    blk9 = 8'hBE;
    do_scan(0, 2, -1, -1, -1);

    blk9 = 8'hFF;
    do_scan(0, 2, -1, -1, -1);
    blk9 = 8'hBE;

    do_scan(0, 2, 10, 11, -1);
    exp7 = 8'hBE;

    do_scan(0, 2, -1, -1, 12);
    do_scan(0, 2, -1, -1, -1);

    do_scan(1, 1, -1, -1, -1);
    do_scan(1, 1, -1, -1, -1);

    for (int i = 0; i < 12; i++) begin
      blk7 = 8'($urandom);
      blk8 = 8'($urandom);
      blk9 = 8'($urandom);
      exp7 = ($urandom_range(0, 1) == 0) ? blk7 : blk7 ^ (8'd1 << $urandom_range(0, 7));
      exp8 = ($urandom_range(0, 1) == 0) ? blk8 : blk8 ^ (8'd1 << $urandom_range(0, 7));
      exp9 = ($urandom_range(0, 1) == 0) ? blk9 : blk9 ^ (8'd1 << $urandom_range(0, 7));
      do_scan(i % 2, (i % 2 == 0) ? 2 : 1, -1, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
